// File: rtl/mc_ctrl_fsm_if.sv
// rtl/mc_ctrl_fsm_if.sv - instruction/data memory handshake bundle for mc_ctrl_fsm
interface mc_ctrl_fsm_if;
    logic [31:0] instr_in;
    logic        imem_req;
    logic        imem_ready;
    logic        mem_read_en;
    logic        mem_write_en;
    logic        mem_ready;

    modport master (
        input  instr_in, imem_ready, mem_ready,
        output imem_req, mem_read_en, mem_write_en
    );

    modport slave (
        output instr_in, imem_ready, mem_ready,
        input  imem_req, mem_read_en, mem_write_en
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - RV32I multi-cycle control FSM with bus timeout, traps, CSR and irq entry
module mc_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter bit EN_IRQ      = 1'b1,
    parameter bit EN_CSR      = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mc_ctrl_fsm_if.master        bus,
    input  logic                 zero,
    input  logic                 lt_signed,
    input  logic                 lt_unsigned,
    input  logic                 irq_pending,
    output logic                 pc_write,
    output logic                 pc_sel,
    output logic                 ir_en,
    output logic                 rf_latch_en,
    output logic                 aluout_en,
    output logic [3:0]           alu_sel,
    output logic [1:0]           alu_a_sel,
    output logic [1:0]           alu_b_sel,
    output logic [2:0]           imm_sel,
    output logic                 reg_write,
    output logic [1:0]           wb_sel,
    output logic                 csr_en,
    output logic [1:0]           csr_op,
    output logic                 trap_enter,
    output logic                 trap_irq,
    output logic                 mret_exec,
    output logic [3:0]           trap_cause,
    output logic [3:0]           state_o
);
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9;
    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;
    localparam logic [6:0] OP_REG = 7'b0110011, OP_IMM = 7'b0010011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_LUI = 7'b0110111,
                           OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                           OP_SYSTEM = 7'b1110011, OP_FENCE = 7'b0001111;
    localparam logic [1:0] A_OLDPC = 2'd0, A_RS1 = 2'd1, A_ZERO = 2'd2, A_PC = 2'd3;
    localparam logic [1:0] B_RS2 = 2'd0, B_IMM = 2'd1, B_FOUR = 2'd2;
    localparam logic [1:0] WB_ALU = 2'd0, WB_LOAD = 2'd1, WB_PC4 = 2'd2, WB_CSR = 2'd3;
    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2, CAUSE_BREAK = 4'd3, CAUSE_LD_FAULT = 4'd5,
                           CAUSE_ST_FAULT = 4'd7, CAUSE_ECALL_IRQ = 4'd11;

    localparam int              CW       = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam bit              TMO_EN   = (MEM_TIMEOUT > 0);
    localparam logic [CW-1:0]   TMO_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd3, S_EXECUTE = 4'd4, S_WB = 4'd5,
        S_MEM_READ = 4'd6, S_MEM_WAIT = 4'd7, S_MEM_WRITE = 4'd8, S_BRANCH = 4'd9,
        S_JALR = 4'd10, S_TRAP = 4'd11, S_CSR = 4'd12
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_tmo;
    logic [3:0]    r_trap_cause, w_trap_cause_nxt;
    logic          r_trap_irq, w_trap_set, w_trap_irq_set;

    logic [6:0]    w_opcode;
    logic [2:0]    w_funct3;
    logic [6:0]    w_funct7;
    logic [11:0]   w_imm12;
    logic          w_priv, w_is_ecall, w_is_ebreak, w_is_mret, w_is_csr;
    logic          w_illegal, w_taken, w_tmo_fire, w_unused;

    assign w_opcode    = bus.instr_in[6:0];
    assign w_funct3    = bus.instr_in[14:12];
    assign w_funct7    = bus.instr_in[31:25];
    assign w_imm12     = bus.instr_in[31:20];
    assign w_unused    = ^{bus.instr_in[19:15], bus.instr_in[11:7]};
    assign w_priv      = (w_opcode == OP_SYSTEM) && (w_funct3 == 3'b000);
    assign w_is_ecall  = w_priv && (w_imm12 == 12'h000);
    assign w_is_ebreak = w_priv && (w_imm12 == 12'h001);
    assign w_is_mret   = w_priv && (w_imm12 == 12'h302);
    assign w_is_csr    = (w_opcode == OP_SYSTEM) && (w_funct3 != 3'b000) && (w_funct3 != 3'b100);
    assign w_tmo_fire  = TMO_EN && (r_tmo == TMO_LAST) && !bus.mem_ready;

    assign trap_cause = r_trap_cause;
    assign trap_irq   = r_trap_irq;
    assign state_o    = r_state;

    function automatic logic [3:0] f_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        w_illegal = 1'b0;
        case (w_opcode)
            OP_REG:    w_illegal = (w_funct7 != 7'h00) && (w_funct7 != 7'h20);
            OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC,
            OP_JAL, OP_JALR, OP_FENCE: w_illegal = 1'b0;
            OP_SYSTEM: begin
                if (w_funct3 == 3'b100)
                    w_illegal = 1'b1;
                else if (w_funct3 == 3'b000)
                    w_illegal = !(w_is_ecall || w_is_ebreak || w_is_mret);
                else
                    w_illegal = !EN_CSR;
            end
            default:   w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (w_funct3)
            3'b000:  w_taken = zero;
            3'b001:  w_taken = !zero;
            3'b100:  w_taken = lt_signed;
            3'b101:  w_taken = !lt_signed;
            3'b110:  w_taken = lt_unsigned;
            3'b111:  w_taken = !lt_unsigned;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        imm_sel = IMM_I;
        case (w_opcode)
            OP_STORE:         imm_sel = IMM_S;
            OP_BRANCH:        imm_sel = IMM_B;
            OP_LUI, OP_AUIPC: imm_sel = IMM_U;
            OP_JAL:           imm_sel = IMM_J;
            default:          imm_sel = IMM_I;
        endcase
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_trap_set       = 1'b0;
        w_trap_irq_set   = 1'b0;
        w_trap_cause_nxt = 4'd0;
        pc_write         = 1'b0;
        pc_sel           = 1'b0;
        ir_en            = 1'b0;
        rf_latch_en      = 1'b0;
        aluout_en        = 1'b0;
        alu_sel          = ALU_ADD;
        alu_a_sel        = A_OLDPC;
        alu_b_sel        = B_RS2;
        reg_write        = 1'b0;
        wb_sel           = WB_ALU;
        csr_en           = 1'b0;
        csr_op           = 2'd0;
        trap_enter       = 1'b0;
        mret_exec        = 1'b0;
        bus.imem_req     = 1'b0;
        bus.mem_read_en  = 1'b0;
        bus.mem_write_en = 1'b0;

        case (r_state)
            S_IDLE: w_state_nxt = S_FETCH;
            S_FETCH: begin
                // Interrupts are taken only here, so no instruction or access is ever cut short.
                if (EN_IRQ && irq_pending) begin
                    w_trap_set       = 1'b1;
                    w_trap_irq_set   = 1'b1;
                    w_trap_cause_nxt = CAUSE_ECALL_IRQ;
                    w_state_nxt      = S_TRAP;
                end else begin
                    bus.imem_req = 1'b1;
                    if (bus.imem_ready) begin
                        ir_en       = 1'b1;
                        pc_write    = 1'b1;
                        alu_a_sel   = A_PC;
                        alu_b_sel   = B_FOUR;
                        w_state_nxt = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                rf_latch_en = 1'b1;
                w_state_nxt = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (w_illegal || w_is_ecall || w_is_ebreak) begin
                    w_trap_set       = 1'b1;
                    w_trap_cause_nxt = w_illegal ? CAUSE_ILLEGAL :
                                       w_is_ecall ? CAUSE_ECALL_IRQ : CAUSE_BREAK;
                    w_state_nxt      = S_TRAP;
                end else if (w_is_mret) begin
                    mret_exec   = 1'b1;
                    pc_write    = 1'b1;
                    w_state_nxt = S_FETCH;
                end else if (w_is_csr) begin
                    w_state_nxt = S_CSR;
                end else begin
                    case (w_opcode)
                        OP_REG: begin
                            alu_a_sel = A_RS1; alu_b_sel = B_RS2;
                            alu_sel   = f_alu(w_funct3, w_funct7[5]);
                            aluout_en = 1'b1; w_state_nxt = S_WB;
                        end
                        OP_IMM: begin
                            alu_a_sel = A_RS1; alu_b_sel = B_IMM;
                            alu_sel   = f_alu(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
                            aluout_en = 1'b1; w_state_nxt = S_WB;
                        end
                        OP_LOAD, OP_STORE: begin
                            alu_a_sel   = A_RS1; alu_b_sel = B_IMM; aluout_en = 1'b1;
                            w_state_nxt = (w_opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
                        end
                        OP_BRANCH: begin
                            alu_a_sel   = A_RS1; alu_b_sel = B_RS2; alu_sel = ALU_SUB;
                            w_state_nxt = w_taken ? S_BRANCH : S_FETCH;
                        end
                        OP_LUI, OP_AUIPC: begin
                            alu_a_sel   = (w_opcode == OP_LUI) ? A_ZERO : A_OLDPC;
                            alu_b_sel   = B_IMM; aluout_en = 1'b1; w_state_nxt = S_WB;
                        end
                        OP_JAL, OP_JALR: begin
                            reg_write   = 1'b1; wb_sel = WB_PC4;
                            w_state_nxt = (w_opcode == OP_JAL) ? S_BRANCH : S_JALR;
                        end
                        default: w_state_nxt = S_FETCH;
                    endcase
                end
            end
            S_BRANCH: begin
                alu_a_sel = A_OLDPC; alu_b_sel = B_IMM; pc_write = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_JALR: begin
                alu_a_sel = A_RS1; alu_b_sel = B_IMM; pc_write = 1'b1; pc_sel = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_CSR: begin
                csr_en = 1'b1; csr_op = w_funct3[1:0]; reg_write = 1'b1; wb_sel = WB_CSR;
                w_state_nxt = S_FETCH;
            end
            S_MEM_READ: begin
                bus.mem_read_en = 1'b1;
                w_state_nxt     = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                bus.mem_read_en = 1'b1;
                if (bus.mem_ready) begin
                    w_state_nxt = S_WB;
                end else if (w_tmo_fire) begin
                    w_trap_set = 1'b1; w_trap_cause_nxt = CAUSE_LD_FAULT; w_state_nxt = S_TRAP;
                end
            end
            S_MEM_WRITE: begin
                bus.mem_write_en = 1'b1;
                if (bus.mem_ready) begin
                    w_state_nxt = S_FETCH;
                end else if (w_tmo_fire) begin
                    w_trap_set = 1'b1; w_trap_cause_nxt = CAUSE_ST_FAULT; w_state_nxt = S_TRAP;
                end
            end
            S_WB: begin
                reg_write   = 1'b1;
                wb_sel      = (w_opcode == OP_LOAD) ? WB_LOAD : WB_ALU;
                w_state_nxt = S_FETCH;
            end
            S_TRAP: begin
                trap_enter  = 1'b1;
                pc_write    = 1'b1;
                w_state_nxt = S_FETCH;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_tmo        <= '0;
            r_trap_cause <= 4'd0;
            r_trap_irq   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Count is zero outside the wait states, which gives the clear-on-entry behaviour.
            if ((r_state == S_MEM_WAIT) || (r_state == S_MEM_WRITE)) begin
                if (!bus.mem_ready)
                    r_tmo <= r_tmo + 1'b1;
            end else begin
                r_tmo <= '0;
            end
            if (w_trap_set) begin
                r_trap_cause <= w_trap_cause_nxt;
                r_trap_irq   <= w_trap_irq_set;
            end else if (r_state == S_TRAP) begin
                r_trap_irq   <= 1'b0;
            end
        end
    end
endmodule
